// File: rtl/invsqrt_arbiter_if.sv
// Bundles the requester, response and pipeline-facing signals of invsqrt_arbiter.
//   req_valid/req_data/req_ready  : operand handshake, one lane of 32 bits per requester
//   rsp_valid/rsp_data/rsp_ready  : result handshake, one buffered lane per requester
//   flush/idle                    : drain request and quiescence indication
//   pipe_valid/pipe_data          : operand issued to the shared pipeline
//   pipe_hold                     : freezes every pipeline stage
//   pipe_res_valid/pipe_res_data  : result returned by the pipeline
// Modport master is the environment (requesters and pipeline); slave is the arbiter.
interface invsqrt_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [32*NREQ-1:0]   rsp_data;
  logic [NREQ-1:0]      rsp_ready;
  logic                 flush;
  logic                 idle;
  logic                 pipe_valid;
  logic [31:0]          pipe_data;
  logic                 pipe_hold;
  logic                 pipe_res_valid;
  logic [31:0]          pipe_res_data;

  modport master (
    output req_valid, req_data, rsp_ready, flush, pipe_res_valid, pipe_res_data,
    input  req_ready, rsp_valid, rsp_data, idle, pipe_valid, pipe_data, pipe_hold
  );

  modport slave (
    input  req_valid, req_data, rsp_ready, flush, pipe_res_valid, pipe_res_data,
    output req_ready, rsp_valid, rsp_data, idle, pipe_valid, pipe_data, pipe_hold
  );
endinterface

// File: rtl/invsqrt_arbiter.sv
// Shares one inverse-square-root pipeline between NREQ requesters.
// Round-robin grant drives a registered pipeline input; the owner of each in-flight
// operand is kept in an in-order tag FIFO and each result lands in a one-entry
// response buffer for that owner. When the owner's buffer is still full the whole
// pipeline is frozen via pipe_hold. flush stops new grants until everything drains.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : invsqrt_arbiter_if.slave (request, response, flush/idle, pipeline signals)
// Optional build macro INVSQRT_ARB_STATS_EN adds:
//   stat_clr : synchronous clear of all completion counters (wins over increment)
//   stat_cnt : per-requester 16-bit saturating completed-result counters
module invsqrt_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  invsqrt_arbiter_if.slave     bus
`ifdef INVSQRT_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [16*NREQ-1:0]   stat_cnt
`endif
);

  localparam int unsigned TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        wr_q, rd_q;
  logic [TW-1:0]        tag_mem [DEPTH];
  logic                 pv_q;
  logic [31:0]          pd_q;
  logic [NREQ-1:0]      rv_q;
  logic [32*NREQ-1:0]   rdat_q;

  logic [TW-1:0]        head;
  logic                 fifo_empty;
  logic                 hold;
  logic                 retire;
  logic                 idle_int;
  logic                 any_req;
  logic                 grant_en;
  logic                 grant;
  logic                 found;
  logic [TW-1:0]        winner;
  logic [31:0]          win_data;

  assign head       = tag_mem[rd_q];
  assign fifo_empty = (cnt_q == '0);
  // Owner buffer still occupied and not drained this cycle: freeze the pipeline.
  assign hold       = bus.pipe_res_valid && !fifo_empty && rv_q[head] && !bus.rsp_ready[head];
  // A result with an empty tag FIFO is stale or bogus and is silently dropped.
  assign retire     = bus.pipe_res_valid && !fifo_empty && !hold;
  assign idle_int   = fifo_empty && (rv_q == '0);
  assign any_req    = |bus.req_valid;
  assign grant_en   = (state_q != StDrain) && !bus.flush && (cnt_q < CW'(DEPTH)) && !hold;
  assign grant      = grant_en && found;

  // First valid requester at or after the round-robin pointer, with wrap.
  always_comb begin
    logic [TW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = TW'((32'(rr_q) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner == TW'(i)) win_data = bus.req_data[32*i +: 32];
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[winner] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = TW'((32'(winner) + 1) % NREQ);
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({grant, retire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req && !bus.flush) state_d = StRun;
      StRun: begin
        if (bus.flush)                    state_d = StDrain;
        else if (!any_req && idle_int)    state_d = StIdle;
      end
      StDrain: if (idle_int)              state_d = StIdle;
      default:                            state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      if (grant)  wr_q <= wr_q + AW'(1);
      if (retire) rd_q <= rd_q + AW'(1);
      // The issue register is the pipeline's input stage, so it freezes with the pipe.
      if (grant) begin
        pv_q <= 1'b1;
        pd_q <= win_data;
      end else if (!hold) begin
        pv_q <= 1'b0;
      end
    end
  end

  // Tag storage needs no reset: occupancy is tracked by cnt_q and the pointers.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_q] <= winner;
  end

  // Response buffers; a refill on the same edge as a consume keeps the buffer valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q   <= '0;
      rdat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (retire && (head == TW'(i))) begin
          rv_q[i]           <= 1'b1;
          rdat_q[32*i +: 32] <= bus.pipe_res_data;
        end else if (bus.rsp_ready[i]) begin
          rv_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid  = rv_q;
  assign bus.rsp_data   = rdat_q;
  assign bus.pipe_valid = pv_q;
  assign bus.pipe_data  = pd_q;
  assign bus.pipe_hold  = hold;
  assign bus.idle       = idle_int;

`ifdef INVSQRT_ARB_STATS_EN
  logic [16*NREQ-1:0] stat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (stat_clr) begin
          stat_q[16*i +: 16] <= '0;
        end else if (rv_q[i] && bus.rsp_ready[i] && (stat_q[16*i +: 16] != 16'hFFFF)) begin
          stat_q[16*i +: 16] <= stat_q[16*i +: 16] + 16'd1;
        end
      end
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_invsqrt_arbiter.sv
// Self-checking bench for invsqrt_arbiter: directed phases with randomized data and
// handshakes, compared every cycle against a transaction-level reference model.
module tb_invsqrt_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  invsqrt_arbiter_if #(.NREQ(NREQ)) bus ();

`ifdef INVSQRT_ARB_STATS_EN
  logic               stat_clr = 1'b0;
  logic [16*NREQ-1:0] stat_cnt;
  invsqrt_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );
`else
  invsqrt_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  // Pipeline stub: 4 stages, result = operand + 1, frozen by pipe_hold, not reset.
  logic [32:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
  always @(posedge clk) begin
    if (!bus.pipe_hold) begin
      s0 <= {bus.pipe_valid, bus.pipe_data + 32'd1};
      s1 <= s0;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign bus.pipe_res_valid = s3[32];
  assign bus.pipe_res_data  = s3[31:0];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference model: in-flight list in issue order, one buffer per requester.
  typedef struct {
    int          id;
    logic [31:0] val;
  } item_t;

  item_t            pending[$];
  bit [NREQ-1:0]    bfull;
  logic [31:0]      bval [NREQ];
  int               ptr;
  bit               running, draining;
  bit               pv;
  logic [31:0]      pd;
  int               grants;

  task automatic model_reset();
    pending.delete();
    bfull    = '0;
    for (int i = 0; i < NREQ; i++) bval[i] = '0;
    ptr      = 0;
    running  = 1'b0;
    draining = 1'b0;
    pv       = 1'b0;
    pd       = '0;
  endtask

  function automatic logic [31:0] lane(input logic [32*NREQ-1:0] v, input int i);
    return 32'(v >> (32 * i));
  endfunction

  // Compare DUT outputs with the model, then advance the model to the next edge.
  task automatic model_step();
    logic [NREQ-1:0] rv, want_ready;
    int              h, w, j;
    bit              hold, gnt, retire, idle_now;
    logic [31:0]     wdata;
    item_t           it;
    rv   = bus.req_valid;
    h    = (pending.size() > 0) ? pending[0].id : 0;
    hold = bus.pipe_res_valid && (pending.size() > 0) && bfull[h] && !bus.rsp_ready[h];
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (ptr + k) % NREQ;
      if (w < 0 && 1'(rv >> j)) w = j;
    end
    gnt = !draining && !bus.flush && (pending.size() < DEPTH) && !hold && (w >= 0);
    want_ready = '0;
    if (gnt) want_ready = NREQ'(1) << w;
    idle_now = (pending.size() == 0) && (bfull == '0);

    check("req_ready", 128'(bus.req_ready), 128'(want_ready));
    check("pipe_hold", 128'(bus.pipe_hold), 128'(hold));
    check("rsp_valid", 128'(bus.rsp_valid), 128'(bfull));
    check("idle", 128'(bus.idle), 128'(idle_now));
    check("pipe_valid", 128'(bus.pipe_valid), 128'(pv));
    if (pv) check("pipe_data", 128'(bus.pipe_data), 128'(pd));
    for (int i = 0; i < NREQ; i++)
      if (bfull[i]) check("rsp_data", 128'(lane(bus.rsp_data, i)), 128'(bval[i]));

    retire = bus.pipe_res_valid && (pending.size() > 0) && !hold;
    for (int i = 0; i < NREQ; i++)
      if (bfull[i] && bus.rsp_ready[i]) bfull[i] = 1'b0;
    if (retire) begin
      it = pending.pop_front();
      bfull[it.id] = 1'b1;
      bval[it.id]  = it.val;
    end
    if (gnt) begin
      wdata = lane(bus.req_data, w);
      pending.push_back('{id: w, val: wdata + 32'd1});
      ptr = (w + 1) % NREQ;
      pv  = 1'b1;
      pd  = wdata;
      grants++;
    end else if (!hold) begin
      pv = 1'b0;
    end
    if (draining) begin
      if (idle_now) draining = 1'b0;
    end else if (running) begin
      if (bus.flush) begin
        running  = 1'b0;
        draining = 1'b1;
      end else if (rv == '0 && idle_now) begin
        running = 1'b0;
      end
    end else if (rv != '0 && !bus.flush) begin
      running = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    for (int n = 0; n < limit && bus.idle !== 1'b1; n++) tick();
    check("idle_bound", 128'(bus.idle), 128'(1));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, 128'(bus.req_ready), 128'(0));
    check({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(0));
    check({tag, "_rsp_data"}, 128'(bus.rsp_data), 128'(0));
    check({tag, "_pipe_valid"}, 128'(bus.pipe_valid), 128'(0));
    check({tag, "_pipe_data"}, 128'(bus.pipe_data), 128'(0));
    check({tag, "_pipe_hold"}, 128'(bus.pipe_hold), 128'(0));
    check({tag, "_idle"}, 128'(bus.idle), 128'(1));
  endtask

  function automatic logic [32*NREQ-1:0] rand_data();
    logic [32*NREQ-1:0] d;
    for (int i = 0; i < NREQ; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = '0;
    bus.flush     = 1'b0;
    grants        = 0;
    model_reset();
    #3;
    reset_checks("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Single request: grant same cycle, result six cycles after the grant edge.
    bus.req_valid = 4'b0001;
    bus.req_data  = '0;
    bus.req_data[31:0] = 32'h3F80_0000;
    tick();
    bus.req_valid = '0;
    n = 0;
    while (bus.rsp_valid[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("latency", 128'(n + 1), 128'(6));
    check("single_data", 128'(bus.rsp_data[31:0]), 128'(32'h3F80_0001));
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = '0;
    tick();
    check("single_idle", 128'(bus.idle), 128'(1));

    // Round-robin with all requesters continuously valid, data = i.
    bus.rsp_ready = '1;
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) bus.req_data[32*i +: 32] = 32'(i);
    for (int c = 0; c < 40; c++) tick();
    bus.req_valid = '0;
    wait_idle(40);

    // Backpressure on requester 2.
    bus.rsp_ready = 4'b1011;
    bus.req_data  = rand_data();
    bus.req_valid = 4'b0100;
    g0 = grants;
    for (int c = 0; c < 20 && grants < g0 + 3; c++) begin
      tick();
      bus.req_data = rand_data();
    end
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 12; c++) tick();
    check("bp_hold", 128'(bus.pipe_hold), 128'(1));
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    wait_idle(40);

    // Capacity: only requester 1 drains, everyone issues.
    bus.rsp_ready = 4'b0010;
    bus.req_valid = '1;
    for (int c = 0; c < 40; c++) begin
      bus.req_data = rand_data();
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    wait_idle(60);

    // Flush with five in flight.
    bus.rsp_ready = '0;
    bus.req_valid = '1;
    g0 = grants;
    for (int c = 0; c < 20 && grants < g0 + 5; c++) begin
      bus.req_data = rand_data();
      tick();
    end
    bus.flush = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    for (int c = 0; c < 60 && bus.idle !== 1'b1; c++) begin
      bus.rsp_ready = NREQ'($urandom);
      tick();
    end
    check("flush_idle", 128'(bus.idle), 128'(1));
    bus.rsp_ready = '0;
    tick();
    check("flush_no_grant", 128'(bus.req_ready), 128'(0));
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = NREQ'($urandom);
      bus.req_data  = rand_data();
      bus.rsp_ready = NREQ'($urandom);
      bus.flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    wait_idle(80);

    // Reset with three in flight; stale results must be dropped afterwards.
    bus.rsp_ready = '0;
    bus.req_valid = 4'b0001;
    g0 = grants;
    for (int c = 0; c < 10 && grants < g0 + 3; c++) begin
      bus.req_data = rand_data();
      tick();
    end
    bus.req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("stale_dropped", 128'(bus.rsp_valid), 128'(0));

    // Still functional after reset.
    bus.req_valid = 4'b1000;
    bus.req_data  = rand_data();
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    wait_idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/invsqrt_arbiter.md
Name: invsqrt_arbiter

Overview:
- Shares one inverse-square-root pipeline between NREQ requesters.
- Arbitrates round-robin and drives the pipeline input.
- Tracks the requester ID of each in-flight operand in an in-order tag FIFO, then routes each result back to its owner through a one-entry response buffer per requester.
- Freezes the pipeline when a result's owner buffer is still full, and supports a drain/flush mode.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DEPTH, 8, maximum operands in flight; tag FIFO depth (power of 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  32*NREQ  packed operands; requester i uses bits [32*i+31:32*i].
- req_ready  out  NREQ  operand accepted this cycle (one-hot or zero).
- rsp_valid  out  NREQ  response buffer i holds a result.
- rsp_data  out  32*NREQ  packed results.
- rsp_ready  in  NREQ  requester i consumes its result.
- flush  in  1  request drain: stop granting, wait for empty.
- idle  out  1  no operand in flight and all response buffers empty.
- pipe_valid  out  1  operand to pipeline.
- pipe_data  out  32  operand.
- pipe_hold  out  1  1 freezes every pipeline stage (input capture included).
- pipe_res_valid  in  1  pipeline result valid (held stable while pipe_hold=1).
- pipe_res_data  in  32  pipeline result.

Behaviour:
- Reset values: all req_ready=0, rsp_valid=0, rsp_data=0, pipe_valid=0, pipe_data=0, pipe_hold=0, idle=1, FIFO empty, in-flight count=0, round-robin pointer=0, FSM=IDLE.
- FSM:
  - IDLE→RUN on any req_valid while flush=0.
  - RUN→DRAIN on flush=1.
  - DRAIN→IDLE when in-flight count=0 and no rsp_valid set.
  - RUN→IDLE when no req_valid and idle.
  - In DRAIN, no grants. flush is ignored in IDLE; the block stays IDLE while flush=1.
- Grant:
  - Combinational in RUN (or IDLE with a pending request).
  - Requires in-flight count < DEPTH and pipe_hold=0.
  - Winner = first valid requester at or after the pointer, searching upward with wrap.
  - req_ready[winner]=1 in the same cycle.
  - On grant, the pointer becomes winner+1 mod NREQ.
- Issue: pipe_valid and pipe_data are registered from the granted request (1-cycle issue latency); the winner ID is pushed to the tag FIFO on the same edge.
- Return path:
  - When pipe_res_valid=1, let h = the FIFO head tag.
  - If rsp_valid[h]=0, or rsp_ready[h]=1 this cycle: write rsp_data[h], set rsp_valid[h], pop the FIFO, decrement in-flight.
  - Otherwise assert pipe_hold=1 (combinational) and do not pop.
- Response buffer i clears on rsp_valid[i] & rsp_ready[i], unless it is refilled on the same edge (the refill wins and rsp_valid stays 1).
- Same-cycle issue and retire leave the in-flight count unchanged.
- pipe_res_valid with an empty FIFO is a protocol error: the result is dropped and the count is not changed.
- A mid-operation reset discards all in-flight and buffered data. Its effect is immediate and asynchronous.
- Ordering: results for a given requester return in issue order; across requesters, global issue order.
- Total latency = 1 + pipeline latency + 1 (response register).

Optional Feature:
- Macro: INVSQRT_ARB_STATS_EN.
- When defined:
  - Adds output stat_cnt (16*NREQ): per-requester completed-result counters.
  - A counter increments on each rsp_valid&rsp_ready handshake and saturates at 0xFFFF.
  - Adds input stat_clr (1): synchronously zeroes all counters; clear wins over increment.
  - Counters are reset to 0 by rst.
- When undefined: no ports, no logic.

Test Plan:
Bench pipeline stub: latency 4, returns input+1, honours pipe_hold.
- Single request: req_valid=0001, req_data[0]=0x3F800000 → req_ready[0] same cycle; pipe_valid next cycle; rsp_valid[0]=1 with 0x3F800001 six cycles after grant; idle returns to 1 after rsp_ready.
- Round-robin: all four requesters valid continuously, data=i → grant order 0,1,2,3,0,… with one grant per cycle; each rsp_data[i]=i+1.
- Backpressure: rsp_ready[2]=0, requester 2 issues 3 operands → second result asserts pipe_hold; no grants while held; after rsp_ready[2]=1, results arrive in order with none lost.
- Capacity: rsp_ready held 0 except requester 1, all issuing → in-flight count never exceeds 8; req_ready=0 at 8 outstanding.
- Flush: flush=1 with 5 in flight → no grants; idle=1 after all 5 responses consumed; FSM returns to IDLE.
- Reset mid-flight: assert rst with 3 in flight → all outputs at reset values immediately; stale pipeline results after deassertion are dropped.
